// File: rtl/maria_line_ring.sv
// Ring of NUM_LINES line buffers: a byte expander writes 2-bit pixels into the
// current write line while video plays back a completed line with clear-on-read.
module maria_line_ring #(
   parameter int unsigned LINE_W    = 160,
   parameter int unsigned NUM_LINES = 2,
   parameter int unsigned PAL_BITS  = 3,
   parameter int unsigned IDX_BITS  = 2
) (
   input  logic                          sysclk,
   input  logic                          reset_b,
   input  logic                          obj_start,
   input  logic [7:0]                    obj_x,
   input  logic [PAL_BITS-1:0]           obj_pal,
   input  logic                          obj_wm,
   input  logic                          obj_kangaroo,
   input  logic                          byte_valid,
   input  logic [7:0]                    byte_data,
   output logic                          byte_ready,
   input  logic                          wr_line_done,
   input  logic                          rd_line_next,
   input  logic                          rd_en,
   input  logic [7:0]                    rd_col,
   output logic [PAL_BITS+IDX_BITS-1:0]  rd_pix,
   output logic [$clog2(NUM_LINES)-1:0]  lines_ready,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned PIX_W    = PAL_BITS + IDX_BITS;
   localparam int unsigned PTR_W    = $clog2(NUM_LINES);
   localparam int unsigned CNT_W    = PTR_W;
   localparam int unsigned COL_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int unsigned LAST_PTR = NUM_LINES - 1;
   localparam int unsigned FULL_CNT = NUM_LINES - 1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_EXPAND = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            x_q, x_d;
   logic [PAL_BITS-1:0]   pal_q, pal_d;
   logic                  wm_q, wm_d;
   logic                  kang_q, kang_d;
   logic [7:0]            data_q, data_d;
   logic [2:0]            step_q, step_d;
   logic                  pend_q, pend_d;
   logic                  byte_ready_q, byte_ready_d;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic [PIX_W-1:0]      rd_pix_q, rd_pix_d;

   logic [NUM_LINES-1:0][LINE_W-1:0][PIX_W-1:0] mem_q;

   logic                  wr_en_c;
   logic [PIX_W-1:0]      wr_pix_c;
   logic                  wr_adv_c;
   logic                  last_c;
   logic [1:0]            field_sel_c;
   logic [1:0]            field_c;
   logic                  rd_hit_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(LAST_PTR)) ? '0 : p + PTR_W'(1);
   endfunction

   // Expander FSM state register
   always_ff @(posedge sysclk) begin
      if (!reset_b) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         pal_q        <= '0;
         wm_q         <= 1'b0;
         kang_q       <= 1'b0;
         data_q       <= '0;
         step_q       <= '0;
         pend_q       <= 1'b0;
         byte_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         pal_q        <= pal_d;
         wm_q         <= wm_d;
         kang_q       <= kang_d;
         data_q       <= data_d;
         step_q       <= step_d;
         pend_q       <= pend_d;
         byte_ready_q <= byte_ready_d;
      end
   end

   // Expander next-state: one pixel per cycle, deferred line-done in EXPAND
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      pal_d        = pal_q;
      wm_d         = wm_q;
      kang_d       = kang_q;
      data_d       = data_q;
      step_d       = step_q;
      pend_d       = pend_q;
      byte_ready_d = byte_ready_q;
      wr_en_c      = 1'b0;
      wr_pix_c     = '0;
      wr_adv_c     = 1'b0;
      last_c       = 1'b0;
      field_sel_c  = '0;
      field_c      = '0;

      case (state_q)
         S_IDLE: begin
            wr_adv_c = wr_line_done;
            if (byte_valid) begin
               state_d      = S_EXPAND;
               data_d       = byte_data;
               step_d       = '0;
               byte_ready_d = 1'b0;
            end
         end
         S_EXPAND: begin
            field_sel_c = wm_q ? step_q[2:1] : step_q[1:0];
            case (field_sel_c)
               2'd0:    field_c = data_q[7:6];
               2'd1:    field_c = data_q[5:4];
               2'd2:    field_c = data_q[3:2];
               default: field_c = data_q[1:0];
            endcase
            last_c   = wm_q ? (step_q == 3'd7) : (step_q == 3'd3);
            wr_en_c  = ((field_c != 2'b00) || kang_q) && ({1'b0, x_q} < 9'(LINE_W));
            wr_pix_c = {pal_q, IDX_BITS'(field_c)};
            x_d      = x_q + 8'd1;
            step_d   = step_q + 3'd1;
            if (last_c) begin
               state_d      = S_IDLE;
               byte_ready_d = 1'b1;
               wr_adv_c     = pend_q | wr_line_done;
               pend_d       = 1'b0;
            end else begin
               pend_d = pend_q | wr_line_done;
            end
         end
         default: begin
            state_d      = S_IDLE;
            byte_ready_d = 1'b1;
         end
      endcase

      // New object attributes apply to the byte accepted on the same edge
      if (obj_start) begin
         x_d    = obj_x;
         pal_d  = obj_pal;
         wm_d   = obj_wm;
         kang_d = obj_kangaroo;
      end
   end

   // Line pointer / count / sticky flag next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (wr_adv_c && rd_line_next) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (wr_adv_c) begin
         if (count_q < CNT_W'(FULL_CNT)) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + CNT_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end else if (rd_line_next) begin
         if (count_q != '0) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q - CNT_W'(1);
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   // Playback data path; holds when rd_en is low
   always_comb begin
      rd_hit_c = ({1'b0, rd_col} < 9'(LINE_W));
      rd_pix_d = rd_pix_q;
      if (rd_en) begin
         rd_pix_d = rd_hit_c ? mem_q[rd_ptr_q][rd_col[COL_W-1:0]] : '0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reset_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= PTR_W'(1 % NUM_LINES);
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rd_pix_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         rd_pix_q <= rd_pix_d;
      end
   end

   // Line storage: clear-on-read, then expander write (write wins on a collision)
   always_ff @(posedge sysclk) begin
      if (!reset_b) begin
         mem_q <= '0;
      end else begin
         if (rd_en && rd_hit_c) begin
            mem_q[rd_ptr_q][rd_col[COL_W-1:0]] <= '0;
         end
         if (wr_en_c) begin
            mem_q[wr_ptr_q][x_q[COL_W-1:0]] <= wr_pix_c;
         end
      end
   end

   assign byte_ready  = byte_ready_q;
   assign rd_pix      = rd_pix_q;
   assign lines_ready = count_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule
